// File: rtl/layer4_feature_packer_pkg.sv
// Shared Layer4 definitions: feature/beat geometry and the AXI-Stream beat type
// that crosses from the Layer3 feature stage into the Layer4 SVM.
package layer4_feature_packer_pkg;

  localparam int L4_FEAT_W = 16;
  localparam int L4_LANES  = 8;
  localparam int L4_BEAT_W = L4_FEAT_W * L4_LANES;

  typedef struct packed {
    logic [L4_BEAT_W-1:0] tdata;
    logic                 tlast;
  } axis_beat_t;

endpackage

// File: rtl/layer4_feature_packer.sv
// Packs a stream of FEAT_W features into LANES-wide beats, closing each image on
// feat_TLAST or on the N_FEAT count and flagging any disagreement between them.
module layer4_feature_packer
  import layer4_feature_packer_pkg::*;
#(
  parameter int FEAT_W = L4_FEAT_W,
  parameter int LANES  = L4_LANES,
  parameter int N_FEAT = 256
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [FEAT_W-1:0]         feat_TDATA,
  input  logic                      feat_TVALID,
  input  logic                      feat_TLAST,
  output logic                      feat_TREADY,
  output logic [LANES*FEAT_W-1:0]   a_Data_TDATA,
  output logic                      a_Data_TVALID,
  output logic                      a_Data_TLAST,
  input  logic                      a_Data_TREADY,
  output logic                      frame_err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_FEAT - 1);

  logic [LW-1:0]                  r_lane;
  logic [CW-1:0]                  r_cnt;
  logic [LANES-1:0][FEAT_W-1:0]   r_asm;
  axis_beat_t                     r_out;
  logic                           r_vld;
  logic                           r_err;

  logic                           w_at_end;
  logic                           w_close;
  logic                           w_complete;
  logic                           w_ready;
  logic                           w_hs;
  logic [LANES-1:0][FEAT_W-1:0]   w_beat;

  assign w_at_end   = (r_cnt == CNT_LAST);
  assign w_close    = w_at_end || feat_TLAST;
  assign w_complete = (r_lane == LANE_LAST) || w_close;
  // Only a completing feature needs the output register; it may reuse it in the
  // same cycle the current beat drains.
  assign w_ready    = !ap_rst && (!w_complete || !r_vld || a_Data_TREADY);
  assign w_hs       = feat_TVALID && w_ready;

  // Lanes above r_lane are already zero because r_asm is cleared on every close,
  // so an early close pads with zeros for free.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_beat[k] = (r_lane == LW'(k)) ? feat_TDATA : r_asm[k];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_lane <= '0;
      r_cnt  <= '0;
      r_asm  <= '0;
      r_out  <= '0;
      r_vld  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_hs && w_complete) begin
        r_lane      <= '0;
        r_asm       <= '0;
        r_cnt       <= w_close ? '0 : r_cnt + CW'(1);
        r_out.tdata <= w_beat;
        r_out.tlast <= w_close;
        r_vld       <= 1'b1;
        if (w_at_end != feat_TLAST) r_err <= 1'b1;
      end else begin
        if (w_hs) begin
          r_asm[r_lane] <= feat_TDATA;
          r_lane        <= r_lane + LW'(1);
          r_cnt         <= r_cnt + CW'(1);
        end
        if (a_Data_TREADY) r_vld <= 1'b0;
      end
    end
  end

  assign feat_TREADY   = w_ready;
  assign a_Data_TDATA  = r_out.tdata;
  assign a_Data_TLAST  = r_out.tlast;
  assign a_Data_TVALID = r_vld;
  assign frame_err     = r_err;

endmodule

// File: tb/tb_layer4_feature_packer.sv
// Scoreboard bench: two packers (N_FEAT=256 and N_FEAT=20) driven by directed
// images; expected beats are queued by the drivers and checked by monitors.
module tb_layer4_feature_packer;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic         ap_clk, ap_rst;
  logic [15:0]  f_data [2];
  logic         f_vld  [2];
  logic         f_last [2];
  logic         f_rdy  [2];
  logic [127:0] a_data [2];
  logic         a_vld  [2];
  logic         a_last [2];
  logic         a_rdy  [2];
  logic         ferr   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   stall_mode = 0;
  int   cyc = 0;

  layer4_feature_packer #(.FEAT_W(16), .LANES(8), .N_FEAT(256)) u_dut256 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .feat_TDATA(f_data[0]), .feat_TVALID(f_vld[0]), .feat_TLAST(f_last[0]),
    .feat_TREADY(f_rdy[0]),
    .a_Data_TDATA(a_data[0]), .a_Data_TVALID(a_vld[0]), .a_Data_TLAST(a_last[0]),
    .a_Data_TREADY(a_rdy[0]), .frame_err(ferr[0]));

  layer4_feature_packer #(.FEAT_W(16), .LANES(8), .N_FEAT(20)) u_dut20 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .feat_TDATA(f_data[1]), .feat_TVALID(f_vld[1]), .feat_TLAST(f_last[1]),
    .feat_TREADY(f_rdy[1]),
    .a_Data_TDATA(a_data[1]), .a_Data_TVALID(a_vld[1]), .a_Data_TLAST(a_last[1]),
    .a_Data_TREADY(a_rdy[1]), .frame_err(ferr[1]));

  initial begin
    ap_clk = 0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // downstream ready: 1-of-3 cycles in stall mode
  initial begin
    a_rdy[0] = 1; a_rdy[1] = 1;
    forever begin
      @(posedge ap_clk); #1;
      cyc++;
      a_rdy[0] = stall_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Drive one feature, wait for its handshake, and check feat_TREADY each cycle.
  task automatic drive(input int d, input logic [15:0] v, input logic last, input bit cmp);
    bit ok;
    ok = 0;
    f_data[d] = v; f_last[d] = last; f_vld[d] = 1;
    for (int t = 0; t < 100; t++) begin
      @(negedge ap_clk);
      chk("feat_tready", 128'(f_rdy[d]),
          128'(!(cmp && a_vld[d] && !a_rdy[d])));
      ok = f_rdy[d];
      @(posedge ap_clk); #1;
      if (ok) break;
    end
    f_vld[d] = 0; f_last[d] = 0;
    if (!ok) chk("feat_handshake_timeout", 128'd0, 128'd1);
  endtask

  // Send n features val=base+i, TLAST on index tl (-1: none), image size nf.
  task automatic send_img(input int d, input int n, input int base, input int tl, input int nf);
    logic [127:0] acc;
    int lane;
    bit last, cmp;
    exp_t e;
    acc = '0; lane = 0;
    for (int i = 0; i < n; i++) begin
      last = (i == tl);
      cmp  = (lane == 7) || (i == nf - 1) || last;
      acc[lane*16 +: 16] = 16'(base + i);
      drive(d, 16'(base + i), last, cmp);
      if (cmp) begin
        e.data = acc; e.last = last || (i == nf - 1);
        push(d, e);
        acc = '0; lane = 0;
      end else lane++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge ap_clk);
    repeat (3) @(posedge ap_clk);
    #1;
  endtask

  // monitors
  for (genvar d = 0; d < 2; d++) begin : g_mon
    initial begin
      exp_t e;
      logic [127:0] pdata;
      logic plast;
      bit pstall;
      pstall = 0; pdata = '0; plast = 0;
      forever begin
        @(negedge ap_clk);
        if (pstall && !ap_rst) begin
          chk("hold_valid", 128'(a_vld[d]), 128'd1);
          chk("hold_data", a_data[d], pdata);
          chk("hold_last", 128'(a_last[d]), 128'(plast));
        end
        pstall = a_vld[d] && !a_rdy[d] && !ap_rst;
        pdata = a_data[d]; plast = a_last[d];
        if (a_vld[d] && a_rdy[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_beat", a_data[d], 128'd0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("beat_data", a_data[d], e.data);
            chk("beat_last", 128'(a_last[d]), 128'(e.last));
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      f_data[d] = '0; f_vld[d] = 0; f_last[d] = 0;
    end
    ap_rst = 0;
    #1 ap_rst = 1;
    #2;
    chk("rst_tvalid", 128'(a_vld[0]), 128'd0);
    chk("rst_tdata", a_data[0], 128'd0);
    chk("rst_tready", 128'(f_rdy[0]), 128'd0);
    chk("rst_ferr", 128'(ferr[0]), 128'd0);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 0;
    @(posedge ap_clk); #1;

    // full 256-feature image, TLAST on 255
    send_img(0, 256, 0, 255, 256);
    drain();
    chk("ferr_clean_image", 128'(ferr[0]), 128'd0);

    // same with downstream stalling 2 of 3 cycles
    stall_mode = 1;
    send_img(0, 256, 16'hA000, 255, 256);
    drain();
    stall_mode = 0;
    chk("ferr_stall_image", 128'(ferr[0]), 128'd0);

    // N_FEAT=20 with TLAST on the 20th feature
    send_img(1, 20, 0, 19, 20);
    drain();
    chk("ferr20_clean", 128'(ferr[1]), 128'd0);

    // N_FEAT=20 with TLAST missing: closed by count
    send_img(1, 20, 16'h0100, -1, 20);
    drain();
    chk("ferr20_missing", 128'(ferr[1]), 128'd1);

    // early TLAST on feature 99
    send_img(0, 100, 0, 99, 256);
    drain();
    chk("ferr_early", 128'(ferr[0]), 128'd1);

    // next image starts in lane 0; reset pulsed after feature 37
    send_img(0, 38, 16'h7000, -1, 256);
    drain();
    ap_rst = 1;
    #1;
    chk("rst2_tvalid", 128'(a_vld[0]), 128'd0);
    chk("rst2_tlast", 128'(a_last[0]), 128'd0);
    chk("rst2_tdata", a_data[0], 128'd0);
    chk("rst2_ferr", 128'(ferr[0]), 128'd0);
    chk("rst2_tready", 128'(f_rdy[0]), 128'd0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 0;
    @(posedge ap_clk); #1;

    send_img(0, 256, 16'h5000, 255, 256);
    drain();
    chk("ferr_after_reset", 128'(ferr[0]), 128'd0);
    chk("q0_empty", 128'(q0.size()), 128'd0);
    chk("q1_empty", 128'(q1.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
